knn_distance_scheduler: RTL and testbench

//  Sequences distance_calculator over a set of stored training samples for one query. Streams each
//  M*N-element sample from the training and input memories in bursts of MAX_ELEMENTS words. Drives
//  the ready / data_request / done handshake. Hands each (distance, type, index) result to the

---
 rtl/knn_distance_scheduler.sv | 170 +++++++++++++++++
 tb/tb_knn_distance_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_distance_scheduler.sv
// Streams every stored training sample of one query into distance_calculator in fixed-size
// bursts, collects each sample's distance and hands it to the k-nearest sorter.
module knn_distance_scheduler #(
    parameter int M            = 2,
    parameter int N            = 4,
    parameter int W            = 32,
    parameter int MAX_ELEMENTS = 2,
    parameter int TYPE_W       = 2,
    parameter int IDX_W        = 8,
    parameter int ADDR_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IDX_W-1:0]          num_samples,
    output logic                      busy,
    output logic                      all_done,
    output logic [ADDR_W-1:0]         train_addr,
    output logic [ADDR_W-1:0]         input_addr,
    output logic                      mem_rd,
    input  logic [W-1:0]              train_word,
    input  logic [W-1:0]              input_word,
    input  logic [TYPE_W-1:0]         train_type,
    output logic                      dc_ready,
    output logic [W*MAX_ELEMENTS-1:0] dc_training_data,
    output logic [TYPE_W-1:0]         dc_training_type,
    output logic [W*MAX_ELEMENTS-1:0] dc_input_data,
    input  logic                      dc_data_request,
    input  logic                      dc_done,
    input  logic [2*W-1:0]            dc_distance,
    input  logic [TYPE_W-1:0]         dc_type,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*W-1:0]            res_distance,
    output logic [TYPE_W-1:0]         res_type,
    output logic [IDX_W-1:0]          res_index
);

    localparam int E       = M * N;
    localparam int EL_W    = $clog2(E + 1);
    localparam int SL_W    = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;
    localparam int BURST_W = W * MAX_ELEMENTS;

    localparam logic [EL_W-1:0] ELEM_LAST = EL_W'(E - 1);
    localparam logic [EL_W-1:0] ELEM_END  = EL_W'(E);
    localparam logic [SL_W-1:0] SLOT_LAST = SL_W'(MAX_ELEMENTS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, PACK, SEND, WAIT_REQ, WAIT_DONE, EMIT, FINISH
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  num_lat;
    logic [IDX_W-1:0]  sample;
    logic [IDX_W-1:0]  sample_next;
    logic [ADDR_W-1:0] base;
    logic [EL_W-1:0]   elem;
    logic [SL_W-1:0]   slot;
    logic              rd_q;
    logic [SL_W-1:0]   slot_q;
    logic              first_q;

    assign sample_next = sample + IDX_W'(1);

    // Addresses are forced to zero whenever no read is issued.
    assign train_addr = mem_rd ? (base + ADDR_W'(elem)) : '0;
    assign input_addr = mem_rd ? ADDR_W'(elem) : '0;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        busy       = 1'b1;
        all_done   = 1'b0;
        mem_rd     = 1'b0;
        dc_ready   = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = (num_samples == '0) ? FINISH : FETCH;
            end
            FETCH: begin
                mem_rd = 1'b1;
                if (slot == SLOT_LAST || elem == ELEM_LAST) state_next = PACK;
            end
            PACK:      state_next = SEND;
            SEND: begin
                dc_ready   = 1'b1;
                state_next = (elem == ELEM_END) ? WAIT_DONE : WAIT_REQ;
            end
            WAIT_REQ:  if (dc_data_request) state_next = FETCH;
            WAIT_DONE: if (dc_done) state_next = EMIT;
            EMIT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = (sample_next == num_lat) ? FINISH : FETCH;
            end
            FINISH: begin
                busy       = 1'b0;
                all_done   = 1'b1;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            num_lat          <= '0;
            sample           <= '0;
            base             <= '0;
            elem             <= '0;
            slot             <= '0;
            rd_q             <= 1'b0;
            slot_q           <= '0;
            first_q          <= 1'b0;
            dc_training_data <= '0;
            dc_input_data    <= '0;
            dc_training_type <= '0;
            res_distance     <= '0;
            res_type         <= '0;
            res_index        <= '0;
        end else begin
            state   <= state_next;
            rd_q    <= mem_rd;
            slot_q  <= slot;
            first_q <= mem_rd && (elem == '0);

            case (state)
                IDLE: if (start) begin
                    num_lat <= num_samples;
                    sample  <= '0;
                    base    <= '0;
                    elem    <= '0;
                    slot    <= '0;
                end
                FETCH: begin
                    elem <= elem + EL_W'(1);
                    slot <= (state_next == PACK) ? '0 : slot + SL_W'(1);
                end
                WAIT_DONE: if (dc_done) begin
                    res_distance <= dc_distance;
                    res_type     <= dc_type;
                    res_index    <= sample;
                    elem         <= '0;
                end
                EMIT: if (res_ready) begin
                    sample <= sample_next;
                    base   <= base + ADDR_W'(E);
                end
                default: ;
            endcase

            // Memory data lands one cycle after its read; slot 0 also clears the rest of the
            // burst so a short final burst carries zeros in its unused slots.
            if (rd_q) begin
                if (slot_q == '0) begin
                    dc_training_data <= BURST_W'(train_word);
                    dc_input_data    <= BURST_W'(input_word);
                end else begin
                    dc_training_data[int'(slot_q)*W +: W] <= train_word;
                    dc_input_data[int'(slot_q)*W +: W]    <= input_word;
                end
                if (first_q) dc_training_type <= train_type;
            end
        end
    end

endmodule

// File: tb/tb_knn_distance_scheduler.sv
// Bench for knn_distance_scheduler: memory and calculator models around an 8-element instance
// and a 5-element instance, with expected results computed straight from the memory contents.
module tb_knn_distance_scheduler;

    localparam int E_A  = 8;
    localparam int NB_A = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // ---------------- instance A: M=2, N=4 ----------------
    logic        start = 1'b0;
    logic [7:0]  num_samples = '0;
    logic        busy, all_done, mem_rd, dc_ready, res_valid;
    logic [15:0] train_addr, input_addr;
    logic [31:0] train_word = '0, input_word = '0;
    logic [1:0]  train_type = '0;
    logic [63:0] dc_training_data, dc_input_data;
    logic [1:0]  dc_training_type;
    logic        dc_data_request = 1'b0, dc_done = 1'b0;
    logic [63:0] dc_distance = '0;
    logic [1:0]  dc_type = '0;
    logic        res_ready = 1'b0;
    logic [63:0] res_distance;
    logic [1:0]  res_type;
    logic [7:0]  res_index;

    logic [31:0] train_mem [64];
    logic [31:0] input_mem [8];
    logic [1:0]  type_mem  [8];

    knn_distance_scheduler dut_a (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .busy(busy), .all_done(all_done), .train_addr(train_addr), .input_addr(input_addr),
        .mem_rd(mem_rd), .train_word(train_word), .input_word(input_word),
        .train_type(train_type), .dc_ready(dc_ready), .dc_training_data(dc_training_data),
        .dc_training_type(dc_training_type), .dc_input_data(dc_input_data),
        .dc_data_request(dc_data_request), .dc_done(dc_done), .dc_distance(dc_distance),
        .dc_type(dc_type), .res_valid(res_valid), .res_ready(res_ready),
        .res_distance(res_distance), .res_type(res_type), .res_index(res_index)
    );

    always @(posedge clk) if (mem_rd) begin
        train_word <= train_mem[train_addr[5:0]];
        input_word <= input_mem[input_addr[2:0]];
        train_type <= type_mem[train_addr[5:3]];
    end

    // ---------------- instance B: M=1, N=5 ----------------
    logic        start_b = 1'b0;
    logic [7:0]  num_samples_b = '0;
    logic        busy_b, all_done_b, mem_rd_b, dc_ready_b, res_valid_b;
    logic [15:0] train_addr_b, input_addr_b;
    logic [31:0] train_word_b = '0, input_word_b = '0;
    logic [1:0]  train_type_b = '0;
    logic [63:0] dc_training_data_b, dc_input_data_b;
    logic [1:0]  dc_training_type_b;
    logic        dc_data_request_b = 1'b0, dc_done_b = 1'b0;
    logic [63:0] dc_distance_b = '0;
    logic [1:0]  dc_type_b = '0;
    logic        res_ready_b = 1'b0;
    logic [63:0] res_distance_b;
    logic [1:0]  res_type_b;
    logic [7:0]  res_index_b;

    logic [31:0] train_mem_b [8];
    logic [31:0] input_mem_b [8];

    knn_distance_scheduler #(.M(1), .N(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .num_samples(num_samples_b),
        .busy(busy_b), .all_done(all_done_b), .train_addr(train_addr_b),
        .input_addr(input_addr_b), .mem_rd(mem_rd_b), .train_word(train_word_b),
        .input_word(input_word_b), .train_type(train_type_b), .dc_ready(dc_ready_b),
        .dc_training_data(dc_training_data_b), .dc_training_type(dc_training_type_b),
        .dc_input_data(dc_input_data_b), .dc_data_request(dc_data_request_b),
        .dc_done(dc_done_b), .dc_distance(dc_distance_b), .dc_type(dc_type_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b), .res_distance(res_distance_b),
        .res_type(res_type_b), .res_index(res_index_b)
    );

    always @(posedge clk) if (mem_rd_b) begin
        train_word_b <= train_mem_b[train_addr_b[2:0]];
        input_word_b <= input_mem_b[input_addr_b[2:0]];
        train_type_b <= 2'd3;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sqd(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] d;
        d = $signed({32'b0, a}) - $signed({32'b0, b});
        return d * d;
    endfunction

    function automatic logic [63:0] exp_dist(input int s);
        logic [63:0] acc = '0;
        for (int e = 0; e < E_A; e++) acc += sqd(train_mem[s*E_A + e], input_mem[e]);
        return acc;
    endfunction

    task automatic fill_a(input bit ones);
        for (int i = 0; i < 64; i++) train_mem[i] = ones ? 32'd1 : 32'($urandom_range(0, 65535));
        for (int i = 0; i < 8; i++) begin
            input_mem[i] = ones ? 32'd0 : 32'($urandom_range(0, 65535));
            type_mem[i]  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_ctrl"}, {busy, all_done, mem_rd, dc_ready, res_valid}, '0);
        check({tag, "_addr"}, {train_addr, input_addr}, '0);
        check({tag, "_dcbus"}, dc_training_data | dc_input_data | 64'(dc_training_type), '0);
        check({tag, "_res"}, res_distance | 64'({res_type, res_index}), '0);
    endtask

    // Runs one query on instance A. The calculator model answers 2 cycles after each burst and
    // returns the sum of squared differences of what it received.
    task automatic run_a(input int ns, input int stall_len, input bit abort_wr, input bit poke);
        int          accepts = 0, nb_seen = 0, ready_cnt = 0, rd_cnt = 0, cd = 0, max_addr = -1;
        int          stall_left = stall_len;
        bit          pending = 0, finished = 0, stall_ok = 1, seen = 0, idle_ok = 1;
        logic [63:0] acc = '0, held_dist = '0, exp_t, exp_i;
        logic [1:0]  held_type = '0, calc_type = '0;
        logic [7:0]  held_idx = '0;
        start = 1'b1;
        num_samples = 8'(ns);
        @(negedge clk);
        start = 1'b0;
        num_samples = 8'd200;
        check("busy_after_start", busy, 1'b1);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            start = 1'b0; dc_data_request = 1'b0; dc_done = 1'b0; res_ready = 1'b0;
            if (pending) begin
                pending = 0;
                check("res_valid_drop", res_valid, 1'b0);
                if (accepts == ns) begin
                    check("all_done_after_last", all_done, 1'b1);
                    check("busy_low_at_done", busy, 1'b0);
                    finished = 1;
                end
            end
            if (mem_rd) begin
                rd_cnt++;
                if (int'(train_addr) > max_addr) max_addr = int'(train_addr);
            end
            if (dc_ready) begin
                ready_cnt++;
                exp_t = {train_mem[accepts*E_A + nb_seen*2 + 1], train_mem[accepts*E_A + nb_seen*2]};
                exp_i = {input_mem[nb_seen*2 + 1], input_mem[nb_seen*2]};
                check("burst_train", dc_training_data, exp_t);
                check("burst_input", dc_input_data, exp_i);
                check("burst_type", dc_training_type, type_mem[accepts]);
                for (int j = 0; j < 2; j++)
                    acc += sqd(dc_training_data[j*32 +: 32], dc_input_data[j*32 +: 32]);
                calc_type = dc_training_type;
                nb_seen++;
                cd = 2;
                if (poke && ready_cnt == 1) begin
                    start = 1'b1;
                    num_samples = 8'd7;
                end
                if (abort_wr && nb_seen == 1) begin
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    check_a_zero("rst_in_wait_req");
                    rst = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        if ({busy, mem_rd, dc_ready, res_valid} !== 4'b0) idle_ok = 0;
                    end
                    check("quiet_after_rst", idle_ok, 1'b1);
                    return;
                end
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (nb_seen < NB_A) dc_data_request = 1'b1;
                    else begin
                        dc_done = 1'b1; dc_distance = acc; dc_type = calc_type;
                        acc = '0; nb_seen = 0;
                    end
                end
            end
            if (res_valid) begin
                if (!seen) begin
                    seen = 1;
                    held_dist = res_distance; held_type = res_type; held_idx = res_index;
                    check("res_distance", res_distance, exp_dist(accepts));
                    check("res_type", res_type, type_mem[accepts]);
                    check("res_index", res_index, 8'(accepts));
                end
                if (stall_left > 0) begin
                    if (res_distance !== held_dist || res_type !== held_type ||
                        res_index !== held_idx || mem_rd !== 1'b0) stall_ok = 0;
                    stall_left--;
                end else begin
                    res_ready = 1'b1; pending = 1; accepts++; seen = 0;
                end
            end
            @(negedge clk);
        end
        check("query_finished", finished, 1'b1);
        check("dc_ready_count", ready_cnt, ns * NB_A);
        check("mem_rd_count", rd_cnt, ns * E_A);
        check("max_train_addr", max_addr, ns * E_A - 1);
        check("accept_count", accepts, ns);
        if (stall_len > 0) check("stall_stable", stall_ok, 1'b1);
        check("all_done_one_cycle", {all_done, busy}, 2'b00);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          nb_b = 0;
        bit          cd_b = 0, done_b = 0, zero_ok = 1;
        logic [63:0] acc_b = '0, exp_b = '0;

        fill_a(0);
        for (int i = 0; i < 8; i++) begin
            train_mem_b[i] = 32'($urandom_range(1, 65535));
            input_mem_b[i] = 32'($urandom_range(0, 65535));
        end
        repeat (3) @(negedge clk);
        check_a_zero("reset");
        check("reset_b", {busy_b, all_done_b, mem_rd_b, dc_ready_b, res_valid_b}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Empty query: immediate all_done, no traffic.
        start = 1'b1; num_samples = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_all_done", all_done, 1'b1);
        check("zero_busy", busy, 1'b0);
        if (mem_rd || dc_ready) zero_ok = 0;
        @(negedge clk);
        if (mem_rd || dc_ready) zero_ok = 0;
        check("zero_pulse_end", {all_done, busy}, 2'b00);
        check("zero_no_traffic", zero_ok, 1'b1);

        run_a(1, 0, 0, 0);
        fill_a(1);
        run_a(3, 0, 0, 1);
        fill_a(0);
        run_a(2, 10, 0, 0);
        run_a(2, 0, 1, 0);
        run_a(2, 0, 0, 0);

        // Partial final burst on the 5-element instance; calculator answers at once.
        for (int e = 0; e < 5; e++) exp_b += sqd(train_mem_b[e], input_mem_b[e]);
        start_b = 1'b1; num_samples_b = 8'd1;
        @(negedge clk);
        start_b = 1'b0;
        for (int cyc = 0; cyc < 300 && !done_b; cyc++) begin
            dc_data_request_b = 1'b0; dc_done_b = 1'b0; res_ready_b = 1'b0;
            if (all_done_b) done_b = 1;
            if (cd_b) begin
                cd_b = 0;
                if (nb_b < 3) dc_data_request_b = 1'b1;
                else begin
                    dc_done_b = 1'b1; dc_distance_b = acc_b; dc_type_b = dc_training_type_b;
                end
            end
            if (dc_ready_b) begin
                for (int j = 0; j < 2; j++)
                    if (nb_b*2 + j < 5)
                        acc_b += sqd(dc_training_data_b[j*32 +: 32], dc_input_data_b[j*32 +: 32]);
                nb_b++;
                if (nb_b == 3) begin
                    check("e5_last_train", dc_training_data_b, {32'h0, train_mem_b[4]});
                    check("e5_last_input", dc_input_data_b, {32'h0, input_mem_b[4]});
                end
                cd_b = 1;
            end
            if (res_valid_b) begin
                res_ready_b = 1'b1;
                check("e5_res_distance", res_distance_b, exp_b);
                check("e5_res_meta", {res_type_b, res_index_b}, {2'd3, 8'd0});
            end
            @(negedge clk);
        end
        check("e5_finished", done_b, 1'b1);
        check("e5_burst_count", nb_b, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
